// File: rtl/debug_mode_ctrl.sv
// Debug-mode entry/exit sequencer: halt events, drain, halted, resume; DPC/cause capture and MPRV gating.
// Optional drain timeout enabled by defining DBG_TIMEOUT_EN.
module debug_mode_ctrl #(
  parameter int XLEN           = 64,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            debug_req_i,
  input  logic            ebreak_i,
  input  logic            commit_valid_i,
  input  logic [XLEN-1:0] commit_pc_i,
  input  logic [XLEN-1:0] next_pc_i,
  input  logic            step_i,
  input  logic            dret_i,
  input  logic            flush_ack_i,
  input  logic            resume_ack_i,
  input  logic            mprven_i,
  input  logic            mstatus_mprv_i,
  input  logic [1:0]      mstatus_mpp_i,
  input  logic [1:0]      priv_lvl_i,
  output logic            flush_o,
  output logic            resume_o,
  output logic            debug_mode_o,
  output logic [XLEN-1:0] dpc_o,
  output logic [2:0]      dcause_o,
  output logic            mprv_o,
  output logic [1:0]      ld_st_priv_o,
  output logic            halt_timeout_o
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2,
    ST_RESUME = 2'd3
  } state_e;

  localparam logic [2:0] CAUSE_EBREAK  = 3'd1;
  localparam logic [2:0] CAUSE_HALTREQ = 3'd3;
  localparam logic [2:0] CAUSE_STEP    = 3'd4;

  state_e          state_q, state_d;
  logic            debug_mode_q, debug_mode_d;
  logic [XLEN-1:0] dpc_q, dpc_d;
  logic [2:0]      dcause_q, dcause_d;
  logic            step_armed_q, step_armed_d;
  logic            mprv_q, mprv_d;
  logic [1:0]      ld_st_priv_q, ld_st_priv_d;

`ifdef DBG_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0]     tmo_cnt_q, tmo_cnt_d;
  logic            halt_timeout_q, halt_timeout_d;
`endif

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path can infer a latch.
    state_d      = state_q;
    debug_mode_d = debug_mode_q;
    dpc_d        = dpc_q;
    dcause_d     = dcause_q;
    step_armed_d = step_armed_q;
`ifdef DBG_TIMEOUT_EN
    tmo_cnt_d      = tmo_cnt_q;
    halt_timeout_d = halt_timeout_q;
`endif

    unique case (state_q)
      ST_RUN: begin
        // Halt priority: ebreak, then haltreq, then a single-step retirement.
        if (commit_valid_i && ebreak_i) begin
          dpc_d        = commit_pc_i;
          dcause_d     = CAUSE_EBREAK;
          step_armed_d = 1'b0;
          state_d      = ST_DRAIN;
        end else if (debug_req_i) begin
          dpc_d        = next_pc_i;
          dcause_d     = CAUSE_HALTREQ;
          step_armed_d = 1'b0;
          state_d      = ST_DRAIN;
        end else if (step_armed_q && commit_valid_i) begin
          dpc_d        = next_pc_i;
          dcause_d     = CAUSE_STEP;
          step_armed_d = 1'b0;
          state_d      = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (flush_ack_i) begin
          state_d      = ST_HALTED;
          debug_mode_d = 1'b1;
`ifdef DBG_TIMEOUT_EN
          tmo_cnt_d    = '0;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d        = ST_HALTED;
          debug_mode_d   = 1'b1;
          halt_timeout_d = 1'b1;
          tmo_cnt_d      = '0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
`endif
        end
      end
      ST_HALTED: begin
        if (dret_i) begin
          state_d      = ST_RESUME;
          step_armed_d = step_i;
`ifdef DBG_TIMEOUT_EN
          halt_timeout_d = 1'b0;
`endif
        end
      end
      ST_RESUME: begin
        if (resume_ack_i) begin
          state_d      = ST_RUN;
          debug_mode_d = 1'b0;
        end
      end
      default: begin
        state_d      = ST_RUN;
        debug_mode_d = 1'b0;
      end
    endcase

    // Suppression applies only in debug mode; the privilege mux follows the value being loaded.
    mprv_d       = (debug_mode_q && !mprven_i) ? 1'b0 : mstatus_mprv_i;
    ld_st_priv_d = mprv_d ? mstatus_mpp_i : priv_lvl_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_RUN;
      debug_mode_q <= 1'b0;
      dpc_q        <= '0;
      dcause_q     <= '0;
      step_armed_q <= 1'b0;
      mprv_q       <= 1'b0;
      ld_st_priv_q <= '0;
`ifdef DBG_TIMEOUT_EN
      tmo_cnt_q      <= '0;
      halt_timeout_q <= 1'b0;
`endif
    end else begin
      // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
      state_q      <= state_d;
      debug_mode_q <= debug_mode_d;
      dpc_q        <= dpc_d;
      dcause_q     <= dcause_d;
      step_armed_q <= step_armed_d;
      mprv_q       <= mprv_d;
      ld_st_priv_q <= ld_st_priv_d;
`ifdef DBG_TIMEOUT_EN
      tmo_cnt_q      <= tmo_cnt_d;
      halt_timeout_q <= halt_timeout_d;
`endif
    end
  end

  assign flush_o      = (state_q == ST_DRAIN);
  assign resume_o     = (state_q == ST_RESUME);
  assign debug_mode_o = debug_mode_q;
  assign dpc_o        = dpc_q;
  assign dcause_o     = dcause_q;
  assign mprv_o       = mprv_q;
  assign ld_st_priv_o = ld_st_priv_q;
`ifdef DBG_TIMEOUT_EN
  assign halt_timeout_o = halt_timeout_q;
`else
  assign halt_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_debug_mode_ctrl.sv
// Scoreboard bench for debug_mode_ctrl: each halt pushes its expected DPC/cause/drain length,
// a negedge monitor pops and compares on every debug-mode entry.
module tb_debug_mode_ctrl;

  localparam int XLEN = 64;
  localparam int TMO  = 8;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            debug_req_i, ebreak_i, commit_valid_i;
  logic [XLEN-1:0] commit_pc_i, next_pc_i;
  logic            step_i, dret_i, flush_ack_i, resume_ack_i;
  logic            mprven_i, mstatus_mprv_i;
  logic [1:0]      mstatus_mpp_i, priv_lvl_i;
  logic            flush_o, resume_o, debug_mode_o;
  logic [XLEN-1:0] dpc_o;
  logic [2:0]      dcause_o;
  logic            mprv_o;
  logic [1:0]      ld_st_priv_o;
  logic            halt_timeout_o;

  debug_mode_ctrl #(.XLEN(XLEN), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .debug_req_i    (debug_req_i),
    .ebreak_i       (ebreak_i),
    .commit_valid_i (commit_valid_i),
    .commit_pc_i    (commit_pc_i),
    .next_pc_i      (next_pc_i),
    .step_i         (step_i),
    .dret_i         (dret_i),
    .flush_ack_i    (flush_ack_i),
    .resume_ack_i   (resume_ack_i),
    .mprven_i       (mprven_i),
    .mstatus_mprv_i (mstatus_mprv_i),
    .mstatus_mpp_i  (mstatus_mpp_i),
    .priv_lvl_i     (priv_lvl_i),
    .flush_o        (flush_o),
    .resume_o       (resume_o),
    .debug_mode_o   (debug_mode_o),
    .dpc_o          (dpc_o),
    .dcause_o       (dcause_o),
    .mprv_o         (mprv_o),
    .ld_st_priv_o   (ld_st_priv_o),
    .halt_timeout_o (halt_timeout_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [XLEN-1:0] dpc;
    logic [2:0]      cause;
    int              flushes;
  } halt_exp_t;

  halt_exp_t sb_q[$];
  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_halt(input logic [XLEN-1:0] dpc, input logic [2:0] cause, input int flushes);
    halt_exp_t e;
    e.dpc     = dpc;
    e.cause   = cause;
    e.flushes = flushes;
    sb_q.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_flush"},      64'(flush_o),        64'd0);
    check({tag, "_resume"},     64'(resume_o),       64'd0);
    check({tag, "_debug_mode"}, 64'(debug_mode_o),   64'd0);
    check({tag, "_dpc"},        dpc_o,               64'd0);
    check({tag, "_dcause"},     64'(dcause_o),       64'd0);
    check({tag, "_mprv"},       64'(mprv_o),         64'd0);
    check({tag, "_ld_st_priv"}, 64'(ld_st_priv_o),   64'd0);
    check({tag, "_timeout"},    64'(halt_timeout_o), 64'd0);
  endtask

  // Resume from HALTED with the given step bit; ends in the first RUN cycle.
  task automatic do_resume(input logic step);
    dret_i = 1'b1;
    step_i = step;
    tick();
    dret_i       = 1'b0;
    step_i       = 1'b0;
    resume_ack_i = 1'b1;
    tick();
    resume_ack_i = 1'b0;
  endtask

  // Monitor: counts DRAIN cycles and scores every entry into debug mode.
  initial begin
    int  flush_cnt = 0;
    logic prev_dm  = 1'b0;
    halt_exp_t e;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        flush_cnt = 0;
        prev_dm   = 1'b0;
      end else begin
        if (flush_o) flush_cnt++;
        if (debug_mode_o && !prev_dm) begin
          if (sb_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL halt_unexpected: got halt dpc=0x%0h cause=%0d expected no halt", dpc_o, dcause_o);
          end else begin
            e = sb_q.pop_front();
            check("halt_dpc",    dpc_o,            e.dpc);
            check("halt_cause",  64'(dcause_o),    64'(e.cause));
            check("halt_drains", 64'(flush_cnt),   64'(e.flushes));
          end
          flush_cnt = 0;
        end
        prev_dm = debug_mode_o;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i = 1'b1;
    debug_req_i = 1'b0; ebreak_i = 1'b0; commit_valid_i = 1'b0;
    commit_pc_i = '0; next_pc_i = '0;
    step_i = 1'b0; dret_i = 1'b0; flush_ack_i = 1'b0; resume_ack_i = 1'b0;
    mprven_i = 1'b0; mstatus_mprv_i = 1'b1; mstatus_mpp_i = 2'd3; priv_lvl_i = 2'd0;
    tick();
    tick();
    check_all_zero("reset");
    rst_i = 1'b0;

    // Running, mprven=0: MPRV passes through.
    tick();
    check("run_mprv",      64'(mprv_o),       64'd1);
    check("run_ld_st_priv", 64'(ld_st_priv_o), 64'd3);

    // Haltreq with a 3-cycle drain.
    debug_req_i = 1'b1;
    next_pc_i   = 64'h8000_0040;
    push_halt(64'h8000_0040, 3'd3, 3);
    tick();
    debug_req_i = 1'b0;
    check("drain_flush", 64'(flush_o), 64'd1);
    tick();
    tick();
    flush_ack_i = 1'b1;
    tick();
    flush_ack_i = 1'b0;
    check("halted_debug_mode", 64'(debug_mode_o), 64'd1);
    check("halted_flush",      64'(flush_o),      64'd0);

    // Halted MPRV gating.
    tick();
    check("halt_mprven0_mprv", 64'(mprv_o),       64'd0);
    check("halt_mprven0_priv", 64'(ld_st_priv_o), 64'd0);
    mprven_i = 1'b1;
    tick();
    check("halt_mprven1_mprv", 64'(mprv_o),       64'd1);
    check("halt_mprven1_priv", 64'(ld_st_priv_o), 64'd3);
    mprven_i = 1'b0;

    // Haltreq ignored while halted; still high at resume -> re-halt.
    debug_req_i = 1'b1;
    next_pc_i   = 64'h3000;
    tick();
    check("halted_req_ignored_flush", 64'(flush_o),      64'd0);
    check("halted_req_ignored_dm",    64'(debug_mode_o), 64'd1);
    dret_i = 1'b1;
    tick();
    dret_i = 1'b0;
    check("resume_req", 64'(resume_o),     64'd1);
    check("resume_dm",  64'(debug_mode_o), 64'd1);
    tick();
    check("resume_hold", 64'(resume_o), 64'd1);
    push_halt(64'h3000, 3'd3, 1);
    resume_ack_i = 1'b1;
    tick();
    resume_ack_i = 1'b0;
    check("rerun_dm",     64'(debug_mode_o), 64'd0);
    check("rerun_resume", 64'(resume_o),     64'd0);
    tick();
    check("rehalt_flush", 64'(flush_o), 64'd1);
    debug_req_i = 1'b0;
    flush_ack_i = 1'b1;
    tick();
    flush_ack_i = 1'b0;

    // Ebreak beats a concurrent haltreq.
    do_resume(1'b0);
    commit_valid_i = 1'b1; ebreak_i = 1'b1; debug_req_i = 1'b1;
    commit_pc_i    = 64'h1000; next_pc_i = 64'h1004;
    push_halt(64'h1000, 3'd1, 1);
    tick();
    commit_valid_i = 1'b0; ebreak_i = 1'b0; debug_req_i = 1'b0;
    flush_ack_i = 1'b1;
    tick();
    flush_ack_i = 1'b0;

    // Single step: idle RUN cycles do not halt, first retirement does.
    do_resume(1'b1);
    tick();
    check("step_idle_dm",    64'(debug_mode_o), 64'd0);
    check("step_idle_flush", 64'(flush_o),      64'd0);
    commit_valid_i = 1'b1; commit_pc_i = 64'h2000; next_pc_i = 64'h2004;
    push_halt(64'h2004, 3'd4, 2);
    tick();
    commit_pc_i = 64'h2004; next_pc_i = 64'h2008;
    tick();
    commit_valid_i = 1'b0;
    flush_ack_i    = 1'b1;
    tick();
    flush_ack_i = 1'b0;

    // Resume without step: retirements must not halt.
    do_resume(1'b0);
    for (int i = 0; i < 3; i++) begin
      commit_valid_i = 1'b1;
      commit_pc_i    = 64'h6000 + 64'(4 * i);
      next_pc_i      = 64'h6004 + 64'(4 * i);
      tick();
      check("nostep_flush", 64'(flush_o), 64'd0);
    end
    commit_valid_i = 1'b0;
    check("nostep_dm", 64'(debug_mode_o), 64'd0);

    // Async reset mid-DRAIN.
    debug_req_i = 1'b1;
    next_pc_i   = 64'h5000;
    tick();
    debug_req_i = 1'b0;
    check("pre_rst_drain", 64'(flush_o), 64'd1);
    #2 rst_i = 1'b1;
    #1;
    check_all_zero("rst_drain");
    tick();
    rst_i = 1'b0;
    tick();
    check("post_rst_drain_flush", 64'(flush_o),      64'd0);
    check("post_rst_drain_dm",    64'(debug_mode_o), 64'd0);

    // Async reset mid-RESUME.
    debug_req_i = 1'b1;
    next_pc_i   = 64'h4000;
    push_halt(64'h4000, 3'd3, 1);
    tick();
    debug_req_i = 1'b0;
    flush_ack_i = 1'b1;
    tick();
    flush_ack_i = 1'b0;
    dret_i      = 1'b1;
    tick();
    dret_i = 1'b0;
    check("pre_rst_resume", 64'(resume_o), 64'd1);
    #2 rst_i = 1'b1;
    #1;
    check_all_zero("rst_resume");
    tick();
    rst_i = 1'b0;
    tick();
    check("post_rst_resume", 64'(resume_o),     64'd0);
    check("post_rst_res_dm", 64'(debug_mode_o), 64'd0);

`ifdef DBG_TIMEOUT_EN
    // Drain never acknowledged: timeout forces HALTED after TMO cycles.
    debug_req_i = 1'b1;
    next_pc_i   = 64'h7000;
    push_halt(64'h7000, 3'd3, TMO);
    tick();
    debug_req_i = 1'b0;
    for (int i = 0; i < 20 && !debug_mode_o; i++) tick();
    check("tmo_halted",  64'(debug_mode_o),   64'd1);
    check("tmo_flag",    64'(halt_timeout_o), 64'd1);
    tick();
    check("tmo_sticky",  64'(halt_timeout_o), 64'd1);
    dret_i = 1'b1;
    tick();
    dret_i = 1'b0;
    check("tmo_cleared", 64'(halt_timeout_o), 64'd0);
    resume_ack_i = 1'b1;
    tick();
    resume_ack_i = 1'b0;
`else
    // Without the timeout, DRAIN waits for the ack indefinitely.
    debug_req_i = 1'b1;
    next_pc_i   = 64'h7000;
    push_halt(64'h7000, 3'd3, 13);
    tick();
    debug_req_i = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    check("stuck_flush", 64'(flush_o),        64'd1);
    check("stuck_dm",    64'(debug_mode_o),   64'd0);
    check("stuck_tmo",   64'(halt_timeout_o), 64'd0);
    flush_ack_i = 1'b1;
    tick();
    flush_ack_i = 1'b0;
    check("stuck_halted", 64'(debug_mode_o), 64'd1);
`endif

    tick();
    tick();
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/debug_mode_ctrl.md
Name: debug_mode_ctrl

Overview:
Sequences core entry into and exit from RISC-V debug mode: halt request, ebreak, single-step, drain and resume handshakes. Owns the architectural debug_mode flag, DPC and DCSR.cause capture. Also produces the registered effective load/store privilege (MPRV gating) that feeds the CSR regfile and LSU. Sits between the debug module interface, the commit stage and the CSR file.

Parameters:
XLEN, 64, PC and DPC width
TIMEOUT_CYCLES, 256, drain timeout limit (used only with DBG_TIMEOUT_EN)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
debug_req_i  in  1  halt request from debug module, level
ebreak_i  in  1  committing instruction is ebreak (with dcsr.ebreakm/s/u already qualified)
commit_valid_i  in  1  one instruction retires this cycle
commit_pc_i  in  XLEN  PC of retiring instruction
next_pc_i  in  XLEN  PC of next instruction to execute
step_i  in  1  dcsr.step
dret_i  in  1  dret executed (valid only while halted)
flush_ack_i  in  1  pipeline drained
resume_ack_i  in  1  frontend redirected to resume PC
mprven_i  in  1  dcsr.mprven
mstatus_mprv_i  in  1  mstatus.MPRV
mstatus_mpp_i  in  2  mstatus.MPP
priv_lvl_i  in  2  current privilege
flush_o  out  1  request pipeline flush/drain
resume_o  out  1  request redirect to dpc_o
debug_mode_o  out  1  core in debug mode
dpc_o  out  XLEN  captured DPC
dcause_o  out  3  DCSR.cause
mprv_o  out  1  effective MPRV
ld_st_priv_o  out  2  effective load/store privilege
halt_timeout_o  out  1  sticky drain-timeout flag

Behaviour:
- Reset (any time, including mid-drain/resume): state RUN; all outputs 0; step_armed cleared.
- States: RUN, DRAIN, HALTED, RESUME.
- RUN: halt event priority ebreak > haltreq > step.
  - commit_valid_i && ebreak_i: dpc <= commit_pc_i, cause <= 1.
  - else debug_req_i: dpc <= next_pc_i, cause <= 3.
  - else step_armed && commit_valid_i: dpc <= next_pc_i, cause <= 4; step_armed cleared.
  - Any event -> DRAIN next cycle.
- DRAIN: flush_o = 1 (combinational on state). flush_ack_i -> HALTED; debug_mode_o = 1 from first HALTED cycle.
- HALTED: flush_o = 0. debug_req_i ignored. dret_i -> RESUME; step_armed <= step_i sampled the same cycle.
- RESUME: resume_o = 1 until resume_ack_i. On ack -> RUN; debug_mode_o = 0 the next cycle.
  - debug_req_i still high in RUN: re-halts one cycle later, cause 3.
- step_armed: a step halt fires on exactly the first commit_valid_i after resume. A concurrent ebreak takes cause 1 and also clears step_armed.
- dpc_o, dcause_o hold their values until the next halt event.
- MPRV gating, registered, 1-cycle latency:
  - mprv_o <= (debug_mode_o && !mprven_i) ? 0 : mstatus_mprv_i.
  - Outside debug mode, MPRV is never suppressed by mprven_i.
  - ld_st_priv_o <= mprv_o_next ? mstatus_mpp_i : priv_lvl_i, where mprv_o_next is the value being loaded into mprv_o the same cycle.
- Illegal/unused state encodings -> RUN.

Optional Feature:
DBG_TIMEOUT_EN:
- Defined:
  - 16-bit counter increments each DRAIN cycle without flush_ack_i.
  - On reaching TIMEOUT_CYCLES - 1 without an ack -> HALTED anyway; halt_timeout_o set.
  - halt_timeout_o is sticky; cleared on dret_i or reset.
  - Counter clears on leaving DRAIN.
- Undefined: DRAIN waits indefinitely; halt_timeout_o tied 0; no counter logic.

Test Plan:
- Haltreq in RUN, next_pc_i=0x8000_0040, flush_ack_i 3 cycles later -> flush_o high 3 cycles, HALTED, debug_mode_o=1, dpc_o=0x8000_0040, dcause_o=3.
- ebreak commit at commit_pc_i=0x1000 with debug_req_i simultaneously high -> dcause_o=1, dpc_o=0x1000.
- step_i=1 at dret, resume_ack_i, then two retirements at 0x2000/0x2004 (next_pc_i=0x2004 on the first) -> halt after the first retirement, dcause_o=4, dpc_o=0x2004.
- MPRV gating (priv_lvl_i=0, mstatus_mprv_i=1, mstatus_mpp_i=3):
  - Halted, mprven_i=0 -> mprv_o=0, ld_st_priv_o=0 one cycle later.
  - Halted, mprven_i=1 -> mprv_o=1, ld_st_priv_o=3.
  - Running, mprven_i=0 -> mprv_o=1, ld_st_priv_o=3.
- rst_i asserted mid-DRAIN and mid-RESUME -> all outputs 0 immediately (async), state RUN after release.
- DBG_TIMEOUT_EN, TIMEOUT_CYCLES=8, flush_ack_i never asserted -> HALTED after 8 DRAIN cycles, halt_timeout_o=1; dret_i clears it.
